msk_and_hpc3_cross_lanes: RTL and testbench

//  L-lane masked AND, HPC3 style, cross-domain terms only (i != j), d shares per operand.
//  Per-lane operand swap fixed at elaboration; single elastic pipeline stage with valid/ready.

---
 rtl/msk_hpc3_pkg.sv | 34 +++
 rtl/msk_hpc3_cross_lane.sv | 82 ++++++++
 rtl/msk_and_hpc3_cross_lanes.sv | 55 +++++
 tb/tb_msk_and_hpc3_cross_lanes.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/msk_hpc3_pkg.sv
// Shared helpers for the HPC3 masked-AND lanes: randomness sizing, pair indexing, lane slicing.
package msk_hpc3_pkg;

    localparam int D_DEFAULT = 2;
    localparam int L_DEFAULT = 4;

    // Fresh random bits per lane per beat: one r and one r2 per unordered share pair.
    function automatic int hpc3_rnd(input int d);
        return d * (d - 1);
    endfunction

    function automatic int pair_cnt(input int d);
        return (d * (d - 1)) / 2;
    endfunction

    // Unordered pair {i,j} -> index, pairs ordered (0,1),(0,2),...,(1,2),...
    function automatic int pair_idx(input int i, input int j, input int d);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * (d - 1) - (lo * (lo - 1)) / 2 + (hi - lo - 1);
    endfunction

    // Ordered pair (i,j), i!=j -> dense index with the diagonal removed.
    function automatic int ord_idx(input int i, input int j, input int d);
        return i * (d - 1) + ((j < i) ? j : j - 1);
    endfunction

    function automatic int lane_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/msk_hpc3_cross_lane.sv
// One HPC3 masked-AND lane, cross-domain terms only; MSKAND_HPC3_INNER_EN adds the
// same-domain x_i&y_i terms so the lane computes a full AND.
module msk_hpc3_cross_lane
    import msk_hpc3_pkg::*;
#(
    parameter int d    = 2,
    parameter bit swap = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [d-1:0]           x,
    input  logic [d-1:0]           y,
    input  logic [hpc3_rnd(d)-1:0] rnd,
    output logic [d-1:0]           out
);
    localparam int P = pair_cnt(d);
    localparam int N = d * (d - 1);

    logic [d-1:0] xm;
    logic [d-1:0] ym;
    logic [N-1:0] u_d;
    logic [N-1:0] v_d;
    logic [N-1:0] u_q;
    logic [N-1:0] v_q;

    // xm is the share-wise multiplier, ym the operand that gets masked by r.
    assign xm = swap ? y : x;
    assign ym = swap ? x : y;

    always_comb begin
        u_d = '0;
        v_d = '0;
        for (int i = 0; i < d; i++) begin
            for (int j = 0; j < d; j++) begin
                if (i != j) begin
                    u_d[ord_idx(i, j, d)] = xm[i] & (ym[j] ^ rnd[pair_idx(i, j, d)]);
                    v_d[ord_idx(i, j, d)] = (xm[i] & rnd[pair_idx(i, j, d)])
                                          ^ rnd[P + pair_idx(i, j, d)];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            u_q <= '0;
            v_q <= '0;
        end else if (en) begin
            u_q <= u_d;
            v_q <= v_d;
        end
    end

`ifdef MSKAND_HPC3_INNER_EN
    logic [d-1:0] w_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q <= '0;
        end else if (en) begin
            w_q <= xm & ym;
        end
    end
`endif

    // Only the XOR tree sits between the product registers and the output.
    always_comb begin
        out = '0;
        for (int i = 0; i < d; i++) begin
            for (int j = 0; j < d; j++) begin
                if (i != j) begin
                    out[i] = out[i] ^ u_q[ord_idx(i, j, d)] ^ v_q[ord_idx(i, j, d)];
                end
            end
        end
`ifdef MSKAND_HPC3_INNER_EN
        out = out ^ w_q;
`endif
    end

endmodule

// File: rtl/msk_and_hpc3_cross_lanes.sv
// L-lane HPC3 masked AND (cross terms) behind one elastic valid/ready stage.
// Define MSKAND_HPC3_INNER_EN to include the same-domain terms (full AND).
module msk_and_hpc3_cross_lanes
    import msk_hpc3_pkg::*;
#(
    parameter int           d    = D_DEFAULT,
    parameter int           L    = L_DEFAULT,
    parameter logic [L-1:0] SWAP = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [L*d-1:0]             ina,
    input  logic [L*d-1:0]             inb,
    input  logic [L*hpc3_rnd(d)-1:0]   rnd,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [L*d-1:0]             out
);
    localparam int R = hpc3_rnd(d);

    logic accept;

    // Handshake: a beat transfers when valid & ready are both high at a rising edge;
    // the source must keep its beat stable until then and offer fresh rnd per transfer.
    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    for (genvar k = 0; k < L; k++) begin : g_lane
        msk_hpc3_cross_lane #(
            .d    (d),
            .swap (SWAP[k])
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .en  (accept),
            .x   (ina[lane_lo(k, d) +: d]),
            .y   (inb[lane_lo(k, d) +: d]),
            .rnd (rnd[lane_lo(k, R) +: R]),
            .out (out[lane_lo(k, d) +: d])
        );
    end

endmodule

// File: tb/tb_msk_and_hpc3_cross_lanes.sv
// Scoreboard bench for msk_and_hpc3_cross_lanes (d=3, L=2, SWAP=2'b10).
module tb_msk_and_hpc3_cross_lanes;

    localparam int D  = 3;
    localparam int L  = 2;
    localparam int R  = D * (D - 1);
    localparam int W  = L * D;
    localparam int RW = L * R;
    localparam logic [L-1:0] SWAP = 2'b10;
`ifdef MSKAND_HPC3_INNER_EN
    localparam bit INNER = 1'b1;
`else
    localparam bit INNER = 1'b0;
`endif

    typedef struct packed {
        logic          chk_full;
        logic [W-1:0]  full;
        logic [L-1:0]  xr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  ina;
    logic [W-1:0]  inb;
    logic [RW-1:0] rnd;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   n_results = 0;
    int   n_pushed  = 0;
    int   n_dropped = 0;
    int   n_waits   = 0;
    logic [W-1:0] held;

    always #5 clk = ~clk;

    msk_and_hpc3_cross_lanes #(
        .d    (D),
        .L    (L),
        .SWAP (SWAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ina       (ina),
        .inb       (inb),
        .rnd       (rnd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Golden XOR of each lane's output shares: cross terms (plus inner terms if enabled).
    function automatic logic [L-1:0] xor_gold(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [L-1:0] g;
        g = '0;
        for (int k = 0; k < L; k++)
            for (int i = 0; i < D; i++)
                for (int j = 0; j < D; j++)
                    if (i != j || INNER) g[k] = g[k] ^ (a[k*D+i] & b[k*D+j]);
        return g;
    endfunction

    // With rnd=0 every share is determined: out_i = x_i & XOR_{j!=i} y_j (^ x_i&y_i).
    function automatic logic [W-1:0] full_gold_r0(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] f;
        logic xi;
        logic acc;
        f = '0;
        for (int k = 0; k < L; k++) begin
            for (int i = 0; i < D; i++) begin
                xi  = SWAP[k] ? b[k*D+i] : a[k*D+i];
                acc = 1'b0;
                for (int j = 0; j < D; j++)
                    if (j != i) acc = acc ^ (SWAP[k] ? a[k*D+j] : b[k*D+j]);
                f[k*D+i] = (xi & acc) ^ (INNER & xi & (SWAP[k] ? a[k*D+i] : b[k*D+i]));
            end
        end
        return f;
    endfunction

    function automatic logic [L-1:0] lane_xor(input logic [W-1:0] v);
        logic [L-1:0] g;
        g = '0;
        for (int k = 0; k < L; k++)
            for (int i = 0; i < D; i++) g[k] = g[k] ^ v[k*D+i];
        return g;
    endfunction

    // Monitor: pop one expectation per transferred result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got out=%0h with no expectation queued", out);
            end else begin
                mon_e = exp_q.pop_front();
                chk("lane_xor", 32'(lane_xor(out)), 32'(mon_e.xr));
                if (mon_e.chk_full) chk("out_shares", 32'(out), 32'(mon_e.full));
                n_results++;
            end
        end
    end

    // Driver: called at posedge+1, returns at posedge+1 after the accepting edge.
    task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [RW-1:0] r, input bit full);
        exp_t e;
        ina      = a;
        inb      = b;
        rnd      = r;
        in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                e.chk_full = full;
                e.full     = full_gold_r0(a, b);
                e.xr       = xor_gold(a, b);
                exp_q.push_back(e);
                n_pushed++;
                if (t != 0) n_waits++;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        n_fail++;
        $display("FAIL accept_timeout: in_ready stayed 0 for 50 cycles, expected 1");
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ina       = W'($urandom);
        inb       = W'($urandom);
        rnd       = RW'($urandom);

        // Reset state, independent of inputs
        #12;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out", 32'(out), 32'd0);
        @(negedge clk);
        in_valid = 1'b1;
        rst      = 1'b0;
        #1;
        chk("post_reset_in_ready", 32'(in_ready), 32'd1);
        chk("post_reset_out", 32'(out), 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_out_valid", 32'(out_valid), 32'd0);

        // Hand-computed: lane0 a=001 b=010 rnd=0 -> share0 = a0&b1 = 1, rest 0
        send_beat(6'b000_001, 6'b000_010, '0, 1'b1);
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        chk("directed_a0b1", 32'(out), 32'h01);

        // Directed rnd=0 vectors, every share checked
        send_beat(6'b011_101, 6'b110_011, '0, 1'b1);
        send_beat(6'b111_111, 6'b101_110, '0, 1'b1);
        send_beat(6'b100_010, 6'b011_111, '0, 1'b1);
        send_beat(6'b010_110, 6'b001_100, '0, 1'b1);
        drain();

        // Exhaustive operands, random rnd, back-to-back streaming
        n_waits = 0;
        for (int a = 0; a < (1 << W); a++)
            for (int b = 0; b < (1 << W); b++)
                send_beat(W'(a), W'(b), RW'($urandom), 1'b0);
        chk("stream_no_stalls", 32'(n_waits), 32'd0);
        drain();

        // Backpressure: result must hold while new beats and rnd churn at the input
        out_ready = 1'b0;
        send_beat(6'b101_011, 6'b011_110, '0, 1'b1);
        held     = out;
        chk("stall_first_value", 32'(held), 32'(full_gold_r0(6'b101_011, 6'b011_110)));
        ina      = 6'b111_000;
        inb      = 6'b000_111;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            rnd = RW'($urandom);
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_out_stable", 32'(out), 32'(held));
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send_beat(6'b111_000, 6'b000_111, '0, 1'b1);
        drain();

        // Reset with a result in flight: dropped immediately, next beat works
        out_ready = 1'b0;
        send_beat(6'b111_111, 6'b111_111, '0, 1'b1);
        chk("inflight_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midreset_out", 32'(out), 32'd0);
        chk("midreset_out_valid", 32'(out_valid), 32'd0);
        n_dropped += exp_q.size();
        exp_q.delete();
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send_beat(6'b011_110, 6'b101_101, '0, 1'b1);
        chk("after_reset_out_valid", 32'(out_valid), 32'd1);
        send_beat(6'b001_100, 6'b110_011, RW'($urandom), 1'b0);
        drain();

        chk("result_count", 32'(n_results), 32'(n_pushed - n_dropped));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
